// File: rtl/mem_access_unit.sv
// mem_access_unit
// Data-memory access engine for LW/LH/LB/SW/SH/SB. It takes one request at a
// time, runs a request/acknowledge transaction on a word-wide memory port,
// and returns sign- or zero-extended load data. Sub-word stores are done as a
// read-modify-write so the untouched byte lanes of the word are preserved.
//
// Ports
//   Clk, Rst             clock, asynchronous active-low reset
//   Req                  request strobe, only sampled in IDLE
//   MemRead, MemWrite    load / store request
//   Size                 00 word, 01 half, 10 byte, 11 illegal
//   SignExt              loads: 1 sign-extend, 0 zero-extend
//   Address, WriteData   byte address and store data
//   Busy, Done, Err      status; Err is qualified by the one-cycle Done
//   ReadData             extended load result, held until the next load
//   MemAddr              word address = Address[ADDR_W+1:2]
//   MemRdEn, MemWrEn     memory read / write request
//   MemWData             memory write data
//   MemRData, MemAck     memory read data and acknowledge
module mem_access_unit #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic              SignExt,
    input  logic [31:0]       Address,
    input  logic [31:0]       WriteData,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [31:0]       ReadData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRdEn,
    output logic              MemWrEn,
    output logic [31:0]       MemWData,
    input  logic [31:0]       MemRData,
    input  logic              MemAck
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             sext_q;
    logic [31:0]      wdata_q;
    logic             err_q;

    logic        bad_req;
    logic        to_hit;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;
    logic [31:0] merge_v;

    // Upper address bits are outside the memory port's reach.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[31:ADDR_W+2];

    assign bad_req = (MemRead && MemWrite) || (Size == 2'b11) ||
                     (Size == 2'b00 && Address[1:0] != 2'b00) ||
                     (Size == 2'b01 && Address[0]);

    // A missing ack on the cycle where cnt already holds TIMEOUT-1 means the
    // enable has been up for TIMEOUT cycles.
    assign to_hit = (cnt == TO_LAST);

    always_comb begin
        byte_v = MemRData[{lane_q, 3'b000} +: 8];
        half_v = lane_q[1] ? MemRData[31:16] : MemRData[15:0];
        case (size_q)
            2'b00:   load_v = MemRData;
            2'b01:   load_v = {{16{sext_q & half_v[15]}}, half_v};
            default: load_v = {{24{sext_q & byte_v[7]}}, byte_v};
        endcase

        merge_v = MemRData;
        if (size_q == 2'b01) begin
            if (lane_q[1]) merge_v[31:16] = wdata_q[15:0];
            else           merge_v[15:0]  = wdata_q[15:0];
        end else begin
            merge_v[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lane_q   <= '0;
            size_q   <= '0;
            sext_q   <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Err      <= 1'b0;
            ReadData <= '0;
            MemAddr  <= '0;
            MemRdEn  <= 1'b0;
            MemWrEn  <= 1'b0;
            MemWData <= '0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Busy is still high here during the Done cycle; it drops
                    // with Done unless a new request is taken at this edge.
                    Busy <= 1'b0;
                    if (Req && (MemRead || MemWrite)) begin
                        Busy    <= 1'b1;
                        lane_q  <= Address[1:0];
                        size_q  <= Size;
                        sext_q  <= SignExt;
                        wdata_q <= WriteData;
                        cnt     <= '0;
                        if (bad_req) begin
                            err_q <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            err_q   <= 1'b0;
                            MemAddr <= Address[ADDR_W+1:2];
                            if (MemRead) begin
                                MemRdEn <= 1'b1;
                                state   <= S_RD;
                            end else if (Size == 2'b00) begin
                                MemWrEn  <= 1'b1;
                                MemWData <= WriteData;
                                state    <= S_WR;
                            end else begin
                                MemRdEn <= 1'b1;
                                state   <= S_RMW_RD;
                            end
                        end
                    end
                end

                S_RD: begin
                    if (MemAck) begin
                        MemRdEn  <= 1'b0;
                        ReadData <= load_v;
                        state    <= S_FIN;
                    end else if (to_hit) begin
                        MemRdEn <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_RMW_RD: begin
                    if (MemAck) begin
                        MemRdEn  <= 1'b0;
                        MemWrEn  <= 1'b1;
                        MemWData <= merge_v;
                        cnt      <= '0;
                        state    <= S_RMW_WR;
                    end else if (to_hit) begin
                        MemRdEn <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_WR, S_RMW_WR: begin
                    if (MemAck) begin
                        MemWrEn <= 1'b0;
                        state   <= S_FIN;
                    end else if (to_hit) begin
                        MemWrEn <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_FIN: begin
                    Done  <= 1'b1;
                    Err   <= err_q;
                    state <= S_IDLE;
                end

                default: begin
                    MemRdEn <= 1'b0;
                    MemWrEn <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access engine that serves the memory-class control outputs of the datapath controller: LW/LH/LB/SW/SH/SB. It takes one request at a time from the execute stage, drives a word-wide memory port with a request/acknowledge handshake, and returns sign- or zero-extended load data. Byte and halfword stores run as read-modify-write so that the other lanes of the word are preserved.

## Interface
- ADDR_W, 10: width of the word address on the memory port.
- TIMEOUT, 15: maximum number of cycles to wait for MemAck before aborting; minimum value 1.
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-low reset.
- Req  in  1  request strobe, sampled only in IDLE.
- MemRead  in  1  load request (from the datapath controller).
- MemWrite  in  1  store request.
- Size  in  2  00 word, 01 half, 10 byte; 11 is illegal.
- SignExt  in  1  loads only: 1 sign-extends, 0 zero-extends.
- Address  in  32  byte address, the ALU result.
- WriteData  in  32  store data; the low lanes are used for SH/SB.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  valid with Done: misaligned, illegal, or timed-out request.
- ReadData  out  32  extended load result; held until the next load completes.
- MemAddr  out  ADDR_W  word address, Address[ADDR_W+1:2].
- MemRdEn  out  1  memory read request.
- MemWrEn  out  1  memory write request.
- MemWData  out  32  memory write data.
- MemRData  in  32  memory read data, valid when MemAck=1.
- MemAck  in  1  memory acknowledge.

## Operation
- Reset values: all outputs 0, state IDLE, timeout counter 0, latched request fields 0.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by Address[1:0]. A halfword uses Address[1] (lanes 0-1 or 2-3).
- States are IDLE, RD, WR, RMW_RD, RMW_WR, FIN.
- IDLE transitions on Req=1 (all request fields are latched at this edge):
  - Neither MemRead nor MemWrite set: the request is ignored and no Done is produced.
  - Both set, Size=11, a word with Address[1:0]≠0, or a half with Address[0]=1: go to FIN with Err=1 and no memory access.
  - Otherwise: a load goes to RD, SW goes to WR, SH/SB go to RMW_RD.
- RD: MemRdEn=1. When MemAck=1, extract the addressed lane(s), extend per SignExt, load ReadData, go to FIN.
- WR: MemWrEn=1, MemWData=WriteData. When MemAck=1, go to FIN.
- RMW_RD: MemRdEn=1. When MemAck=1, merge WriteData[7:0] or [15:0] into the addressed lane(s) of MemRData, register the result as MemWData, go to RMW_WR.
- RMW_WR: MemWrEn=1. When MemAck=1, go to FIN.
- FIN: Done=1, and Err=1 if flagged. Return to IDLE.
- Timeout: the counter resets on entry to each memory state and increments every cycle MemAck=0. On reaching TIMEOUT, deassert the enables, go to FIN with Err=1, and leave ReadData unchanged.
- Req outside IDLE is ignored and never queued.
- Asynchronous reset mid-transaction: outputs clear immediately, the transaction is dropped, and no Done is produced.

## Timing
- All outputs are registered.
- MemRdEn, MemWrEn and MemAddr are stable from the cycle after entering a state until the MemAck edge.
- Enables fall in the cycle after MemAck is sampled.
- Latency from the Req edge to the Done pulse, with MemAck returned in the first enable cycle:
  - LW/LH/LB/SW: 2 cycles.
  - SH/SB: 3 cycles.
  - Error requests: 1 cycle.
- Each wait cycle adds one cycle.
- Busy rises the cycle after Req is accepted and falls in the same cycle Done falls.
- Back-to-back operation: Req may be reasserted in the cycle after FIN; the minimum issue interval is latency + 1.

## Test plan
- LB, Address=0x0000_0007, SignExt=1, MemRData=0x80FF_1234, immediate ack -> MemAddr=1, ReadData=0xFFFF_FF80, Done 2 cycles after Req, Err=0.
- LH zero-extend, Address=0x2, MemRData=0xBEEF_0001 -> ReadData=0x0000_BEEF. The same request with SignExt=1 -> 0xFFFF_BEEF.
- SB, Address=0x5, WriteData=0x0000_00AA, MemRData=0x1122_3344 -> one read then one write with MemWData=0x1122_AA44, MemAddr=1, Done after 3 cycles.
- Misaligned SW, Address=0x6 -> Done and Err after 1 cycle, MemWrEn never asserted.
- LW with MemAck held low -> MemRdEn held for TIMEOUT cycles, then Done and Err, and ReadData keeps its prior value. A separate LW with ack after 3 wait cycles -> Done after 5 cycles.
- Pulse Rst low during RMW_RD of an SH, then issue a new SW with Req while still Busy -> outputs go to 0 immediately, no Done, no write. The SW issued while Busy is ignored; the next SW issued from IDLE completes normally.
